// File: rtl/trace_buffer.sv
// trace_buffer: circular FIFO that sits directly downstream of the tracer.
// Every record strobed with trace_ready_i, while capture is enabled, is stored
// and later presented in order on a valid/ready drain port. The block reports
// its fill level and counts records dropped because the buffer was full.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   trace_ready_i,trace_i tracer strobe and record
//   enable_i              capture enable (draining ignores it)
//   flush_i               synchronous clear of contents and statistics
//   out_valid_o/ready_i   drain handshake; out_data_o is the registered head
//   level_o,full_o,empty_o fill status
//   overflow_o            sticky "a record was dropped" flag
//   overflow_cnt_o        saturating dropped-record count
//
// Option macro TRACE_BUFFER_TIMESTAMP_EN: a free-running 32-bit cycle counter
// is stored with each entry in the upper bits of out_data_o.
module trace_buffer #(
    parameter int TRACE_WIDTH = 96,
    parameter int DEPTH       = 16,
    parameter int OVF_WIDTH   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       trace_ready_i,
    input  logic [TRACE_WIDTH-1:0]     trace_i,
    input  logic                       enable_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    output logic [TRACE_WIDTH+31:0]    out_data_o,
`else
    output logic [TRACE_WIDTH-1:0]     out_data_o,
`endif
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic [OVF_WIDTH-1:0]       overflow_cnt_o
);

`ifdef TRACE_BUFFER_TIMESTAMP_EN
    localparam int DW = TRACE_WIDTH + 32;
`else
    localparam int DW = TRACE_WIDTH;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic                 ovf_q, ovf_d;
    logic [OVF_WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]        head_q, head_d;
    logic [DW-1:0]        din;
    logic                 push_req, pop, push, drop;

`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    assign din  = {ts_q, trace_i};
    assign ts_d = flush_i ? 32'd0 : ts_q + 32'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ts_q <= 32'd0;
        else         ts_q <= ts_d;
    end
`else
    assign din = trace_i;
`endif

    assign empty_o        = (lvl_q == '0);
    assign full_o         = (lvl_q == LW'(DEPTH));
    assign out_valid_o    = ~empty_o;
    assign level_o        = lvl_q;
    assign overflow_o     = ovf_q;
    assign overflow_cnt_o = cnt_q;
    assign out_data_o     = head_q;

    assign push_req = trace_ready_i & enable_i & ~flush_i;
    assign pop      = out_valid_o & out_ready_i & ~flush_i;
    // A same-cycle pop frees the slot, so a full buffer still accepts.
    assign push     = push_req & (~full_o | pop);
    assign drop     = push_req & full_o & ~pop;

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        lvl_d  = lvl_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop) lvl_d = lvl_q + 1'b1;
        if (pop && !push) lvl_d = lvl_q - 1'b1;
        if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        // Registered head: reload from the new read slot, bypassing the
        // record being written when it lands exactly there.
        if ((push || pop) && lvl_d != '0)
            head_d = (push && wr_q == rd_d) ? din : mem_q[rd_d];
        if (flush_i) begin
            rd_d   = '0;
            wr_d   = '0;
            lvl_d  = '0;
            ovf_d  = 1'b0;
            cnt_d  = '0;
            head_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q   <= '0;
            wr_q   <= '0;
            lvl_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            lvl_q  <= lvl_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    // Storage is deliberately not reset; push is already gated by reset-free
    // flush_i, and reset only needs to empty the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem_q[wr_q] <= din;
    end

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;
    localparam int TW    = 96;
    localparam int DEPTH = 16;
    localparam int OW    = 16;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    localparam int DW = TW + 32;
`else
    localparam int DW = TW;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            trace_ready_i = 1'b0;
    logic [TW-1:0]   trace_i = '0;
    logic            enable_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [DW-1:0]   out_data_o;
    logic [4:0]      level_o;
    logic            full_o, empty_o, overflow_o;
    logic [OW-1:0]   overflow_cnt_o;

    trace_buffer #(.TRACE_WIDTH(TW), .DEPTH(DEPTH), .OVF_WIDTH(OW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .trace_ready_i(trace_ready_i),
        .trace_i(trace_i), .enable_i(enable_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .level_o(level_o), .full_o(full_o),
        .empty_o(empty_o), .overflow_o(overflow_o),
        .overflow_cnt_o(overflow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [DW-1:0] sb[$];
    int            mlev = 0;
    int            movf_cnt = 0;
    logic          movf = 1'b0;
    logic [31:0]   mts = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs in the low phase, check the state left by
    // the previous edge against the model, update the model, then let the edge go.
    task automatic cyc(input logic rst, input logic tr, input logic en,
                       input logic [TW-1:0] d, input logic rdy, input logic fl);
        logic preq, mpop, mpush;
        logic [DW-1:0] ent;
        @(negedge clk_i);
        rst_ni = rst; trace_ready_i = tr; enable_i = en; trace_i = d;
        out_ready_i = rdy; flush_i = fl;
        #1;
        chk("valid", out_valid_o, mlev > 0);
        chk("level", level_o, mlev[4:0]);
        chk("empty", empty_o, mlev == 0);
        chk("full", full_o, mlev == DEPTH);
        chk("ovf", overflow_o, movf);
        chk("ovf_cnt", overflow_cnt_o, movf_cnt[OW-1:0]);
        if (mlev > 0) chk("head", out_data_o, sb[0]);
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        ent = {mts, d};
`else
        ent = d;
`endif
        if (!rst || fl) begin
            sb.delete(); mlev = 0; movf = 0; movf_cnt = 0; mts = 0;
        end else begin
            preq  = tr & en;
            mpop  = (mlev > 0) & rdy;
            mpush = preq & ((mlev < DEPTH) | mpop);
            if (mpop) begin void'(sb.pop_front()); mlev--; end
            if (mpush) begin sb.push_back(ent); mlev++; end
            if (preq && !mpush) begin
                movf = 1;
                if (movf_cnt < (1 << OW) - 1) movf_cnt++;
            end
            mts = mts + 1;
        end
        @(posedge clk_i);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, '0, 1, 0);
    endtask

    initial begin
        int pushed, guard;
        // initial reset edge so outputs are defined before checking
        @(posedge clk_i);
        // reset held 3 cycles with the tracer strobing
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, TW'(i + 100), 0, 0);
        #2 chk("rst_data", out_data_o, '0);

        // ordering with a stalled consumer
        cyc(1, 1, 1, TW'('hA), 0, 0);
        cyc(1, 1, 1, TW'('hB), 0, 0);
        cyc(1, 1, 1, TW'('hC), 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        chk("ord_level", level_o, 5'd3);
        chk("ord_head", out_data_o[TW-1:0], 128'hA);
        drain(4);
        chk("ord_empty", empty_o, 1'b1);

        // overflow: 18 pushes, no pops
        for (int i = 1; i <= 18; i++) cyc(1, 1, 1, TW'(i), 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        chk("ovf_full", full_o, 1'b1);
        chk("ovf_cnt2", overflow_cnt_o, 16'd2);
        // disabled capture while full: ignored, not counted
        cyc(1, 1, 0, TW'('h77), 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        chk("en_off_cnt", overflow_cnt_o, 16'd2);
        drain(17);

        // push + pop at full
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 1, TW'(i + 'h20), 0, 0);
        cyc(1, 1, 1, TW'('h55), 1, 0);
        cyc(1, 0, 1, '0, 0, 0);
        chk("pp_level", level_o, 5'd16);
        chk("pp_cnt", overflow_cnt_o, 16'd2);
        drain(17);

        // random traffic across pointer wrap
        pushed = 0; guard = 0;
        while (pushed < 40 && guard < 2000) begin
            logic tr;
            tr = 1'($urandom_range(0, 1));
            if (tr && mlev < DEPTH) pushed++;
            cyc(1, tr, 1, TW'({$urandom, $urandom, $urandom}), 1'($urandom_range(0, 1)), 0);
            guard++;
        end
        chk("rnd_budget", guard < 2000, 1'b1);
        // leave some data and an overflow in place, then flush with a strobe
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, TW'(i + 'h300), 0, 0);
        cyc(1, 1, 1, TW'('hF1), 1, 1);
        cyc(1, 0, 1, '0, 0, 0);
        chk("fl_level", level_o, 5'd0);
        chk("fl_ovf", overflow_o, 1'b0);

        // timestamps restart after flush; push again and drain
        cyc(1, 0, 1, '0, 0, 0);
        cyc(1, 1, 1, TW'('h1234), 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        cyc(1, 1, 1, TW'('h5678), 0, 0);
        drain(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Circular FIFO directly downstream of the dragreder tracer.
- Captures every `trace_o` record the tracer qualifies with `trace_ready`, so no record is lost while the consumer is busy.
- Presents the captured records in order on a valid/ready drain port for the trace sink (debug memory or UART bridge).
- Tracks fill level and counts records dropped on overflow.

Parameters:
- TRACE_WIDTH, 96, bit width of one packed `ryuki_datatypes::trace_output` record.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- OVF_WIDTH, 16, width of the saturating overflow counter.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  synchronous active-low reset.
- trace_ready_i  in  1  tracer strobe: `trace_i` is valid this cycle.
- trace_i  in  TRACE_WIDTH  trace record from the tracer.
- enable_i  in  1  capture enable; draining is independent of it.
- flush_i  in  1  synchronous clear of contents and statistics.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  consumer accepts the head entry.
- out_data_o  out  TRACE_WIDTH (+32 with option)  head entry.
- level_o  out  $clog2(DEPTH)+1  number of stored entries.
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  level_o == 0.
- overflow_o  out  1  sticky: at least one record has been dropped.
- overflow_cnt_o  out  OVF_WIDTH  dropped-record count, saturating.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low; it is sampled on the rising edge of clk_i only.
- Reset values:
  - rd/wr pointers = 0, level_o = 0.
  - empty_o = 1, full_o = 0, out_valid_o = 0.
  - overflow_o = 0, overflow_cnt_o = 0.
  - out_data_o = 0; entry storage is not cleared.
- Reset mid-operation: all in-flight entries are discarded; identical to flush.
- Push condition: `push_req = trace_ready_i & enable_i & ~flush_i`.
- Pop condition: `pop = out_valid_o & out_ready_i & ~flush_i`.
- Push is accepted when `push_req & (~full_o | pop)`. The record is written at wr_ptr and wr_ptr advances modulo DEPTH.
- Push while full without a same-cycle pop:
  - the record is dropped; contents are unchanged;
  - overflow_o is set;
  - overflow_cnt_o increments, saturating at all-ones.
- Pop advances rd_ptr modulo DEPTH.
- level_o update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: a record pushed at edge N shows on out_data_o/out_valid_o in cycle N+1 when the buffer was empty (registered head, no fall-through).
- Drain handshake:
  - out_valid_o = ~empty_o.
  - out_data_o = storage[rd_ptr], stable while out_valid_o & ~out_ready_i.
  - out_valid_o never drops without a pop or flush.
- Simultaneous push and pop on an empty buffer: impossible, since pop requires out_valid_o.
- Simultaneous push and pop at DEPTH: both occur, level stays DEPTH, nothing is dropped.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from level_o, not pointer compare.
- flush_i:
  - highest priority;
  - next cycle pointers = 0, level_o = 0, overflow_o = 0, overflow_cnt_o = 0;
  - any same-cycle push or pop is ignored.
- enable_i low: incoming records are ignored and not counted as overflow; buffered entries continue to drain.

Optional Feature:
- Macro: TRACE_BUFFER_TIMESTAMP_EN.
- Defined:
  - a 32-bit free-running cycle counter runs, 0 on reset and 0 on flush, incrementing every cycle and wrapping.
  - each accepted entry stores {counter value at push edge, trace_i}.
  - out_data_o is TRACE_WIDTH+32 bits, timestamp in the MSBs.
- Undefined: no counter; out_data_o is TRACE_WIDTH bits.

Test Plan:
- Reset: hold rst_ni=0 3 cycles with trace_ready_i=1 -> empty_o=1, level_o=0, out_valid_o=0, overflow_cnt_o=0 throughout; release -> first push appears next cycle.
- Ordering: push records 0xA, 0xB, 0xC on consecutive cycles with out_ready_i=0 -> level_o=3, out_data_o=0xA held stable; then out_ready_i=1 -> 0xA, 0xB, 0xC on successive cycles, then empty_o=1.
- Overflow: push 18 records 1..18, no pops -> full_o=1, level_o=16, overflow_cnt_o=2, overflow_o=1; drain yields 1..16.
- Full push+pop: at level 16, push 0x55 with out_ready_i=1 same cycle -> level_o stays 16, overflow_cnt_o unchanged, 0x55 emerges last.
- Wrap and flush: random push/pop of 40 records -> output order equals input order across wrap; then flush_i with trace_ready_i=1 -> level_o=0, overflow_o=0, record not stored.
- Timestamp (macro defined): push at cycles 10 and 13 after reset release -> MSBs read 10 and 13.
